uart_rx_param: RTL and testbench

- Parametrised successor to the fixed-format UART receiver used on the inter-board data link.
- Adds the following to the receiver:
  - configurable data width, oversampling, parity and stop bits
  - input synchroniser and 3-sample majority vote
  - start-glitch rejection and framing/parity error reporting
  - valid/ready output with a one-entry holding register and overrun detection.
- Sits between the board pin and the message decoder. Default width is the codebase's MESSAGE_SIZE.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_rx_param.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and sizing helpers for the UART blocks.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default payload width of the inter-board message link.
    localparam int MESSAGE_SIZE = 8;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } rx_state_e;

    function automatic int baud_div(input int clk_freq, input int baud_rate, input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Brief    : Free-running divider producing one oversample tick per DIV clocks.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 38400,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int              c_div  = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int              c_cw   = cnt_width(c_div);
    localparam logic [c_cw-1:0] c_last = c_cw'(c_div - 1);

    logic [c_cw-1:0] r_cnt;
    logic            w_tick;

    assign w_tick = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cw'(1);
        end
    end

    assign tick = w_tick;

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parametrised oversampling UART receiver with majority vote,
//            glitch rejection, error flags and a one-entry output holder.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 38400,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = MESSAGE_SIZE,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int              c_mid       = OVERSAMPLE / 2;
    localparam int              c_sw        = cnt_width(OVERSAMPLE);
    localparam int              c_bw        = cnt_width(DATA_BITS);
    localparam logic [c_sw-1:0] c_s_lo      = c_sw'(c_mid - 1);
    localparam logic [c_sw-1:0] c_s_hi      = c_sw'(c_mid + 1);
    localparam logic [c_sw-1:0] c_s_end     = c_sw'(OVERSAMPLE - 1);
    localparam logic [c_bw-1:0] c_b_last    = c_bw'(DATA_BITS - 1);
    localparam logic            c_stop_last = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam parity_e         c_par_mode  = (PARITY == 2) ? PAR_ODD :
                                              (PARITY == 1) ? PAR_EVEN : PAR_NONE;

    rx_state_e            r_state, w_state_next;
    logic                 r_sync1, r_sync2;
    logic [c_sw-1:0]      r_s;
    logic [c_bw-1:0]      r_bit;
    logic                 r_stop_cnt;
    logic [1:0]           r_votes;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr, r_perr;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_ferr_out, r_perr_out, r_overrun;

    logic w_tick, w_rxs, w_vote, w_mid, w_end, w_sample, w_last_bit, w_last_stop;
    logic w_start, w_shift_en, w_bit_inc, w_par_en, w_stop_en, w_stop_inc, w_done;

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RxD;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs       = r_sync2;
    assign w_mid       = (r_s == c_s_hi);
    assign w_end       = (r_s == c_s_end);
    assign w_sample    = (r_s >= c_s_lo) && (r_s <= c_s_hi);
    assign w_last_bit  = (r_bit == c_b_last);
    assign w_last_stop = (r_stop_cnt == c_stop_last);
    // Samples at M-1 and M are held; the M+1 sample is the live line.
    assign w_vote      = (r_votes[1] & r_votes[0]) | (r_votes[1] & w_rxs) | (r_votes[0] & w_rxs);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift_en   = 1'b0;
        w_bit_inc    = 1'b0;
        w_par_en     = 1'b0;
        w_stop_en    = 1'b0;
        w_stop_inc   = 1'b0;
        w_done       = 1'b0;
        if (w_tick) begin
            unique case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        w_start      = 1'b1;
                        w_state_next = START;
                    end
                end
                START: begin
                    if (w_mid && w_vote) begin
                        w_state_next = IDLE;
                    end else if (w_end) begin
                        w_state_next = DATA;
                    end
                end
                DATA: begin
                    w_shift_en = w_mid;
                    if (w_end) begin
                        w_bit_inc = 1'b1;
                        if (w_last_bit) begin
                            w_state_next = (c_par_mode == PAR_NONE) ? STOP : PAR;
                        end
                    end
                end
                PAR: begin
                    w_par_en = w_mid;
                    if (w_end) begin
                        w_state_next = STOP;
                    end
                end
                STOP: begin
                    w_stop_en = w_mid;
                    // Finishing mid-bit leaves half a bit to catch the next start edge.
                    if (w_mid && w_last_stop) begin
                        w_done       = 1'b1;
                        w_state_next = IDLE;
                    end else if (w_end) begin
                        w_stop_inc = 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s        <= '0;
            r_bit      <= '0;
            r_stop_cnt <= 1'b0;
            r_votes    <= 2'b11;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
        end else if (w_tick) begin
            if (w_start) begin
                r_s        <= '0;
                r_bit      <= '0;
                r_stop_cnt <= 1'b0;
                r_ferr     <= 1'b0;
                r_perr     <= 1'b0;
            end else if (r_state != IDLE) begin
                r_s <= w_end ? '0 : r_s + c_sw'(1);
                if (w_sample) begin
                    r_votes <= {r_votes[0], w_rxs};
                end
                if (w_bit_inc) begin
                    r_bit <= w_last_bit ? '0 : r_bit + c_bw'(1);
                end
                if (w_par_en) begin
                    r_perr <= (^r_shift) ^ w_vote ^ (c_par_mode == PAR_ODD);
                end
                if (w_stop_en) begin
                    r_ferr <= r_ferr | ~w_vote;
                end
                if (w_stop_inc) begin
                    r_stop_cnt <= 1'b1;
                end
            end
        end
    end

    generate
        if (DATA_BITS == 1) begin : g_shift_one
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_shift <= '0;
                end else if (w_shift_en) begin
                    r_shift <= w_vote;
                end
            end
        end else begin : g_shift_multi
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_shift <= '0;
                end else if (w_shift_en) begin
                    r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr_out <= 1'b0;
            r_perr_out <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_done && (!r_valid || rx_ready)) begin
                r_data     <= r_shift;
                r_valid    <= 1'b1;
                r_ferr_out <= r_ferr | ~w_vote;
                r_perr_out <= (c_par_mode != PAR_NONE) & r_perr;
            end else if (w_done) begin
                r_overrun <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign frame_err  = r_ferr_out;
    assign parity_err = r_perr_out;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Brief    : Scoreboard bench for uart_rx_param: an 8N1 and an 8E2 receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD_RATE  = 10_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = CLK_FREQ / BAUD_RATE;
    localparam int GAP_CLKS   = 240;
    localparam int N_RANDOM   = 12;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } frame_t;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       rxd_n   = 1'b1;
    logic       rxd_e   = 1'b1;
    logic       ready_n = 1'b1;
    logic       ready_e = 1'b1;
    logic [7:0] data_n, data_e;
    logic       valid_n, valid_e, ferr_n, ferr_e, perr_n, perr_e;
    logic       ovr_n, ovr_e, busy_n, busy_e;

    int     n_checks  = 0;
    int     n_pass    = 0;
    int     ovr_cnt_n = 0;
    int     ovr_cnt_e = 0;
    int     vld_cnt_n = 0;
    frame_t q_n[$];
    frame_t q_e[$];
    frame_t m_exp_n, m_exp_e;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_FREQ (CLK_FREQ), .BAUD_RATE (BAUD_RATE), .OVERSAMPLE (OVERSAMPLE)
    ) u_dut_n (
        .clk (clk), .rst (rst), .RxD (rxd_n), .rx_data (data_n), .rx_valid (valid_n),
        .rx_ready (ready_n), .frame_err (ferr_n), .parity_err (perr_n),
        .overrun (ovr_n), .busy (busy_n)
    );

    uart_rx_param #(
        .CLK_FREQ (CLK_FREQ), .BAUD_RATE (BAUD_RATE), .OVERSAMPLE (OVERSAMPLE),
        .DATA_BITS (8), .PARITY (1), .STOP_BITS (2)
    ) u_dut_e (
        .clk (clk), .rst (rst), .RxD (rxd_e), .rx_data (data_e), .rx_valid (valid_e),
        .rx_ready (ready_e), .frame_err (ferr_e), .parity_err (perr_e),
        .overrun (ovr_e), .busy (busy_e)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst && valid_n && ready_n) begin
            if (q_n.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_frame_n: got data 0x%0h expected no frame", data_n);
            end else begin
                m_exp_n = q_n.pop_front();
                check("data_n", {24'd0, data_n}, {24'd0, m_exp_n.data});
                check("ferr_n", {31'd0, ferr_n}, {31'd0, m_exp_n.ferr});
                check("perr_n", {31'd0, perr_n}, {31'd0, m_exp_n.perr});
            end
        end
        if (valid_n) vld_cnt_n++;
        if (ovr_n) ovr_cnt_n++;
    end

    always @(negedge clk) begin
        if (rst && valid_e && ready_e) begin
            if (q_e.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_frame_e: got data 0x%0h expected no frame", data_e);
            end else begin
                m_exp_e = q_e.pop_front();
                check("data_e", {24'd0, data_e}, {24'd0, m_exp_e.data});
                check("ferr_e", {31'd0, ferr_e}, {31'd0, m_exp_e.ferr});
                check("perr_e", {31'd0, perr_e}, {31'd0, m_exp_e.perr});
            end
        end
        if (ovr_e) ovr_cnt_e++;
    end

    // Consumer on the parity instance applies random back-pressure.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            ready_e = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic hold_bit_n(input logic v, input int clks);
        rxd_n = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_n(input logic [7:0] d, input logic stop_v, input logic push);
        if (push) q_n.push_back(frame_t'{data: d, ferr: ~stop_v, perr: 1'b0});
        hold_bit_n(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold_bit_n(d[i], BIT_CLKS);
        hold_bit_n(stop_v, BIT_CLKS);
        hold_bit_n(1'b1, GAP_CLKS + int'($urandom_range(0, 80)));
    endtask

    task automatic send_e(input logic [7:0] d, input logic par, input logic s1, input logic s2);
        // Even parity: ones in data plus parity bit must be even.
        q_e.push_back(frame_t'{data: d, ferr: ~(s1 & s2), perr: par ^ (^d)});
        rxd_e = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_e = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rxd_e = par;
        repeat (BIT_CLKS) @(negedge clk);
        rxd_e = s1;
        repeat (BIT_CLKS) @(negedge clk);
        rxd_e = s2;
        repeat (BIT_CLKS) @(negedge clk);
        rxd_e = 1'b1;
        repeat (GAP_CLKS + int'($urandom_range(0, 80))) @(negedge clk);
    endtask

    task automatic rand_frame_e();
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        send_e(d, (^d) ^ ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) != 0),
               ($urandom_range(0, 5) != 0));
    endtask

    task automatic set_ready_n(input logic v);
        @(posedge clk);
        #1;
        ready_n = v;
    endtask

    initial begin
        int   base;
        int   waited;
        logic saw_busy;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid_n", {31'd0, valid_n}, 32'd0);
        check("rst_data_n", {24'd0, data_n}, 32'd0);
        check("rst_err_n", {30'd0, ferr_n, perr_n}, 32'd0);
        check("rst_ovr_busy_n", {30'd0, ovr_n, busy_n}, 32'd0);
        check("rst_valid_busy_e", {30'd0, valid_e, busy_e}, 32'd0);
        rst = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);

        base = vld_cnt_n;
        send_n(8'hA5, 1'b1, 1'b1);
        check("t1_valid_cycles", vld_cnt_n - base, 32'd1);
        check("t1_no_overrun", ovr_cnt_n, 32'd0);

        send_e(8'h3C, 1'b1, 1'b1, 1'b1);
        send_e(8'h3C, 1'b0, 1'b1, 1'b1);

        send_n(8'h81, 1'b0, 1'b1);
        send_n(8'h42, 1'b1, 1'b1);

        saw_busy = 1'b0;
        rxd_n = 1'b0;
        repeat (30) begin
            @(negedge clk);
            saw_busy = saw_busy | busy_n;
        end
        rxd_n = 1'b1;
        waited = 0;
        while (waited < BIT_CLKS && !saw_busy) begin
            @(negedge clk);
            saw_busy = busy_n;
            waited++;
        end
        check("t4_busy_rose", {31'd0, saw_busy}, 32'd1);
        waited = 0;
        while (busy_n && waited < BIT_CLKS) begin
            @(negedge clk);
            waited++;
        end
        check("t4_busy_fell", {31'd0, busy_n}, 32'd0);
        repeat (GAP_CLKS) @(negedge clk);
        send_n(8'h5A, 1'b1, 1'b1);

        set_ready_n(1'b0);
        base = ovr_cnt_n;
        send_n(8'h11, 1'b1, 1'b1);
        send_n(8'h22, 1'b1, 1'b0);
        check("t5_overrun_cycles", ovr_cnt_n - base, 32'd1);
        check("t5_held_valid", {31'd0, valid_n}, 32'd1);
        check("t5_held_data", {24'd0, data_n}, 32'h11);
        set_ready_n(1'b1);
        repeat (3) @(negedge clk);
        check("t5_valid_cleared", {31'd0, valid_n}, 32'd0);

        set_ready_n(1'b0);
        send_n(8'h33, 1'b1, 1'b0);
        check("t6_held_before_rst", {23'd0, valid_n, data_n}, {23'd0, 1'b1, 8'h33});
        hold_bit_n(1'b0, BIT_CLKS);
        for (int i = 0; i < 7; i++) hold_bit_n(((8'h77 >> i) & 8'h01) != 0, BIT_CLKS);
        hold_bit_n(1'b0, 100);
        check("t6_busy_mid_frame", {31'd0, busy_n}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_valid_data", {23'd0, valid_n, data_n}, 32'd0);
        check("t6_rst_flags", {29'd0, ferr_n, perr_n, ovr_n}, 32'd0);
        check("t6_rst_busy", {31'd0, busy_n}, 32'd0);
        rst = 1'b1;
        hold_bit_n(1'b0, BIT_CLKS - 101);
        hold_bit_n(1'b1, BIT_CLKS + GAP_CLKS);
        check("t6_no_frame_after_abort", {31'd0, valid_n}, 32'd0);
        set_ready_n(1'b1);
        send_n(8'hC3, 1'b1, 1'b1);

        fork
            begin
                for (int i = 0; i < N_RANDOM; i++)
                    send_n(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), 1'b1);
            end
            begin
                for (int j = 0; j < N_RANDOM; j++) rand_frame_e();
            end
        join

        waited = 0;
        while ((q_n.size() != 0 || q_e.size() != 0) && waited < 20 * BIT_CLKS) begin
            @(negedge clk);
            waited++;
        end
        check("drain_q_n", q_n.size(), 32'd0);
        check("drain_q_e", q_e.size(), 32'd0);
        check("no_overrun_e", ovr_cnt_e, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
